axi_wr_arbiter: RTL and testbench
=================================

Name: axi_wr_arbiter

Overview:
Round-robin write-channel arbiter sharing one AXI-style slave (the same WR_ADDR/WR_DATA/WR_BACK channel set as axi_slave_sim) among M_NUM masters. It grants the address channel to one master and locks the data channel to that master until the last beat. It records the grant order in an outstanding FIFO so write responses are routed back to the correct master. The block sits between the master ports and the slave port.

Parameters:
M_NUM, 2, number of masters (2..4).
OST_DEPTH, 4, outstanding write-response FIFO depth (power of 2, at least 2).

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
M_WR_ADDR  in  M_NUM*32  per-master write address, master i at slice [i*32+:32]
M_WR_ADDR_LEN  in  M_NUM*8  per-master burst length (beats-1)
M_WR_ADDR_ID  in  M_NUM*4  per-master write ID
M_WR_ADDR_VALID  in  M_NUM  address valid
M_WR_ADDR_READY  out  M_NUM  address ready
M_WR_DATA  in  M_NUM*32  write data
M_WR_DATA_LAST  in  M_NUM  last beat
M_WR_DATA_VALID  in  M_NUM  data valid
M_WR_DATA_READY  out  M_NUM  data ready
M_WR_BACK_ID  out  M_NUM*4  response ID
M_WR_BACK_RESP  out  M_NUM*2  response code
M_WR_BACK_VALID  out  M_NUM  response valid
M_WR_BACK_READY  in  M_NUM  response ready
S_WR_ADDR/S_WR_ADDR_LEN/S_WR_ADDR_ID  out  32/8/4  slave address channel
S_WR_ADDR_VALID  out  1; S_WR_ADDR_READY  in  1
S_WR_DATA  out  32; S_WR_DATA_LAST  out  1; S_WR_DATA_VALID  out  1; S_WR_DATA_READY  in  1
S_WR_BACK_ID  in  4; S_WR_BACK_RESP  in  2; S_WR_BACK_VALID  in  1; S_WR_BACK_READY  out  1
bid_err  out  1  sticky response-ID mismatch flag (optional feature)

Behaviour:
- Reset: FSM=IDLE; grant cleared; rr_last=M_NUM-1, so master 0 has highest priority first; FIFO empty. All VALID/READY outputs are 0 and bid_err=0. Reset mid-burst aborts immediately with no further beats forwarded.
- FSM states:
  - IDLE: if any M_WR_ADDR_VALID and the FIFO is not full, select the first requester scanning from (rr_last+1) mod M_NUM upward with wrap. Register gnt_idx and go to ADDR. If the FIFO is full, stay in IDLE and grant nothing.
  - ADDR: the S_WR_ADDR* signals mux from master gnt_idx. M_WR_ADDR_READY[gnt_idx]=S_WR_ADDR_READY; all other ready bits are 0. On the S address handshake, push {gnt_idx, ID} into the FIFO and go to DATA.
  - DATA: the S_WR_DATA* signals mux from gnt_idx, and ready is passed back to that master only. On a data handshake with LAST=1, set rr_last=gnt_idx and go to IDLE.
- All mux paths are combinational from registered gnt_idx and state. Minimum one-cycle bubble from IDLE to address valid at the slave, so back-to-back bursts have 1 idle cycle between the last data beat and the next S_WR_ADDR_VALID.
- The grant holds even if the master drops VALID mid-handshake (protocol violation, not recovered).
- Data beats are counted only for debug. LAST from the master is authoritative.
- Response path, independent of the FSM:
  - When the FIFO is non-empty, the head index h routes S_WR_BACK_VALID/ID/RESP to master h, and S_WR_BACK_READY=M_WR_BACK_READY[h].
  - Pop on the S response handshake.
  - When the FIFO is empty, S_WR_BACK_READY=0 and all M_WR_BACK_VALID=0.
- Simultaneous push (ADDR handshake) and pop (response handshake) in one cycle: both happen and the count is unchanged.
- Response ordering is in-order. The slave returns responses in acceptance order.
- FIFO pointers wrap modulo OST_DEPTH. A count of OST_DEPTH+1 states is needed to distinguish full from empty.

Optional Feature:
WR_ARB_BID_CHECK_EN.
- Defined: on each response handshake, compare S_WR_BACK_ID against the ID stored at the FIFO head. A mismatch sets bid_err=1 on the next cycle; it stays set until reset. The response is still routed by the stored index.
- Undefined: the ID is not stored in the FIFO and bid_err is tied to 0.

Test Plan:
1. Master 0 only: address 0x10, LEN=3, ID=2, four data beats → slave sees 4 beats with LAST on the 4th; the slave's response {ID=2, RESP=0} appears only on master 0's response channel.
2. Both masters raise address valid on the first cycle after reset → master 0 granted first, then master 1, then master 0 again; no beat of one master interleaves with the other's burst.
3. Master 1 requests continuously with LEN=0 while master 0 is idle → consecutive grants to master 1 with exactly 1 idle cycle between S_WR_DATA_LAST and the next S_WR_ADDR_VALID.
4. Slave withholds responses; issue 5 single-beat bursts with OST_DEPTH=4 → the 5th address is not granted until one response handshake completes; then it proceeds.
5. rstn asserted on the 2nd of 4 beats → the next cycle shows all VALID/READY at 0 and state IDLE; a new request afterwards completes normally with the FIFO starting empty.
6. With WR_ARB_BID_CHECK_EN: stored ID 3, slave returns ID 5 → bid_err=1 the following cycle and stays 1 after later matching responses; without the macro, bid_err stays 0.

Source files
------------

// File: rtl/axi_wr_arbiter.sv
// Round-robin write-channel arbiter: M_NUM masters share one slave, responses routed in order.
// Optional WR_ARB_BID_CHECK_EN stores each granted ID and flags response-ID mismatches on bid_err.
module axi_wr_arbiter #(
    parameter int unsigned M_NUM     = 2,
    parameter int unsigned OST_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [M_NUM*32-1:0]   M_WR_ADDR,
    input  logic [M_NUM*8-1:0]    M_WR_ADDR_LEN,
    input  logic [M_NUM*4-1:0]    M_WR_ADDR_ID,
    input  logic [M_NUM-1:0]      M_WR_ADDR_VALID,
    output logic [M_NUM-1:0]      M_WR_ADDR_READY,
    input  logic [M_NUM*32-1:0]   M_WR_DATA,
    input  logic [M_NUM-1:0]      M_WR_DATA_LAST,
    input  logic [M_NUM-1:0]      M_WR_DATA_VALID,
    output logic [M_NUM-1:0]      M_WR_DATA_READY,
    output logic [M_NUM*4-1:0]    M_WR_BACK_ID,
    output logic [M_NUM*2-1:0]    M_WR_BACK_RESP,
    output logic [M_NUM-1:0]      M_WR_BACK_VALID,
    input  logic [M_NUM-1:0]      M_WR_BACK_READY,
    output logic [31:0]           S_WR_ADDR,
    output logic [7:0]            S_WR_ADDR_LEN,
    output logic [3:0]            S_WR_ADDR_ID,
    output logic                  S_WR_ADDR_VALID,
    input  logic                  S_WR_ADDR_READY,
    output logic [31:0]           S_WR_DATA,
    output logic                  S_WR_DATA_LAST,
    output logic                  S_WR_DATA_VALID,
    input  logic                  S_WR_DATA_READY,
    input  logic [3:0]            S_WR_BACK_ID,
    input  logic [1:0]            S_WR_BACK_RESP,
    input  logic                  S_WR_BACK_VALID,
    output logic                  S_WR_BACK_READY,
    output logic                  bid_err
);
    localparam int unsigned IDX_W = (M_NUM > 1) ? $clog2(M_NUM) : 1;
    localparam int unsigned PTR_W = $clog2(OST_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_gnt_idx, w_gnt_nxt;
    logic [IDX_W-1:0] r_rr_last, w_rr_nxt;
    logic [IDX_W-1:0] w_pick;
    logic             w_any_req;
    int unsigned      w_best_d, w_d;

    logic [31:0]      w_m_addr [M_NUM];
    logic [7:0]       w_m_len  [M_NUM];
    logic [3:0]       w_m_id   [M_NUM];
    logic [31:0]      w_m_data [M_NUM];

    logic [IDX_W-1:0] r_fifo_idx [OST_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [IDX_W-1:0] w_head_idx;
    logic             w_empty, w_full, w_push, w_pop, w_w_hs;
    logic [7:0]       r_beat_cnt;

    for (genvar g = 0; g < M_NUM; g++) begin : g_unpack
        assign w_m_addr[g] = M_WR_ADDR[g*32 +: 32];
        assign w_m_len[g]  = M_WR_ADDR_LEN[g*8 +: 8];
        assign w_m_id[g]   = M_WR_ADDR_ID[g*4 +: 4];
        assign w_m_data[g] = M_WR_DATA[g*32 +: 32];
    end

    // Pick the requester closest after rr_last, wrapping around.
    always_comb begin
        w_pick   = '0;
        w_best_d = M_NUM;
        w_d      = 0;
        for (int unsigned i = 0; i < M_NUM; i++) begin
            w_d = (i + 2 * M_NUM - 1 - 32'(r_rr_last)) % M_NUM;
            if (M_WR_ADDR_VALID[i] && (w_d < w_best_d)) begin
                w_best_d = w_d;
                w_pick   = IDX_W'(i);
            end
        end
    end

    assign w_any_req = |M_WR_ADDR_VALID;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_gnt_idx <= '0;
            r_rr_last <= IDX_W'(M_NUM - 1);
        end else begin
            r_state   <= w_state_nxt;
            r_gnt_idx <= w_gnt_nxt;
            r_rr_last <= w_rr_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt_idx;
        w_rr_nxt        = r_rr_last;
        S_WR_ADDR_VALID = 1'b0;
        S_WR_DATA_VALID = 1'b0;
        S_WR_DATA_LAST  = 1'b0;
        M_WR_ADDR_READY = '0;
        M_WR_DATA_READY = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any_req && !w_full) begin
                    w_gnt_nxt   = w_pick;
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                S_WR_ADDR_VALID            = M_WR_ADDR_VALID[r_gnt_idx];
                M_WR_ADDR_READY[r_gnt_idx] = S_WR_ADDR_READY;
                if (M_WR_ADDR_VALID[r_gnt_idx] && S_WR_ADDR_READY) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                S_WR_DATA_VALID            = M_WR_DATA_VALID[r_gnt_idx];
                S_WR_DATA_LAST             = M_WR_DATA_LAST[r_gnt_idx];
                M_WR_DATA_READY[r_gnt_idx] = S_WR_DATA_READY;
                if (M_WR_DATA_VALID[r_gnt_idx] && S_WR_DATA_READY && M_WR_DATA_LAST[r_gnt_idx]) begin
                    w_rr_nxt    = r_gnt_idx;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign S_WR_ADDR     = w_m_addr[r_gnt_idx];
    assign S_WR_ADDR_LEN = w_m_len[r_gnt_idx];
    assign S_WR_ADDR_ID  = w_m_id[r_gnt_idx];
    assign S_WR_DATA     = w_m_data[r_gnt_idx];

    assign w_push = (r_state == ST_ADDR) && M_WR_ADDR_VALID[r_gnt_idx] && S_WR_ADDR_READY;
    assign w_w_hs = (r_state == ST_DATA) && M_WR_DATA_VALID[r_gnt_idx] && S_WR_DATA_READY;

    // Debug-only beat count; LAST from the master ends the burst.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_beat_cnt <= '0;
        end else if (w_push) begin
            r_beat_cnt <= '0;
        end else if (w_w_hs) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
        end
    end

    // Outstanding FIFO of granted master indices, popped on each response handshake.
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(OST_DEPTH));
    assign w_head_idx = r_fifo_idx[r_rd_ptr];
    assign w_pop      = !w_empty && S_WR_BACK_VALID && S_WR_BACK_READY;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_idx[r_wr_ptr] <= r_gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_comb begin
        M_WR_BACK_VALID = '0;
        S_WR_BACK_READY = 1'b0;
        if (!w_empty) begin
            M_WR_BACK_VALID[w_head_idx] = S_WR_BACK_VALID;
            S_WR_BACK_READY             = M_WR_BACK_READY[w_head_idx];
        end
    end

    assign M_WR_BACK_ID   = {M_NUM{S_WR_BACK_ID}};
    assign M_WR_BACK_RESP = {M_NUM{S_WR_BACK_RESP}};

`ifdef WR_ARB_BID_CHECK_EN
    logic [3:0] r_fifo_id [OST_DEPTH];
    logic       r_bid_err;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_id[r_wr_ptr] <= S_WR_ADDR_ID;
        end
    end

    // Sticky until reset; routing still follows the stored index.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_bid_err <= 1'b0;
        end else if (w_pop && (S_WR_BACK_ID != r_fifo_id[r_rd_ptr])) begin
            r_bid_err <= 1'b1;
        end
    end

    assign bid_err = r_bid_err;
`else
    assign bid_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Scoreboard bench for axi_wr_arbiter: directed master bursts, a slave model, and a negedge monitor.
module tb_axi_wr_arbiter;
    localparam int unsigned M_NUM     = 2;
    localparam int unsigned OST_DEPTH = 4;
`ifdef WR_ARB_BID_CHECK_EN
    localparam logic BID_EXP = 1'b1;
`else
    localparam logic BID_EXP = 1'b0;
`endif

    logic clk, rstn;
    logic [31:0] m_awaddr [M_NUM];
    logic [7:0]  m_awlen  [M_NUM];
    logic [3:0]  m_awid   [M_NUM];
    logic [31:0] m_wdata  [M_NUM];
    logic [M_NUM-1:0] m_awvalid, m_wlast, m_wvalid, m_bready;

    logic [M_NUM*32-1:0] w_m_awaddr, w_m_wdata;
    logic [M_NUM*8-1:0]  w_m_awlen;
    logic [M_NUM*4-1:0]  w_m_awid, w_m_bid;
    logic [M_NUM*2-1:0]  w_m_bresp;
    logic [M_NUM-1:0]    w_m_awready, w_m_wready, w_m_bvalid;

    logic [31:0] w_s_awaddr, w_s_wdata;
    logic [7:0]  w_s_awlen;
    logic [3:0]  w_s_awid;
    logic        w_s_awvalid, w_s_wlast, w_s_wvalid, w_s_bready, w_bid_err;
    logic        s_awready, s_wready, s_bvalid;
    logic [3:0]  s_bid, s_bid_xor;
    logic [1:0]  s_bresp, s_resp_code;
    logic        s_resp_en;
    logic [3:0]  s_pend [$];

    logic [43:0] exp_aw [$];
    logic [32:0] exp_w  [$];
    logic [7:0]  exp_b  [$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t_last = 0;
    bit have_last = 1'b0;
    bit gap_mode = 1'b0;

    for (genvar g = 0; g < M_NUM; g++) begin : g_pack
        assign w_m_awaddr[g*32 +: 32] = m_awaddr[g];
        assign w_m_awlen[g*8 +: 8]    = m_awlen[g];
        assign w_m_awid[g*4 +: 4]     = m_awid[g];
        assign w_m_wdata[g*32 +: 32]  = m_wdata[g];
    end

    axi_wr_arbiter #(.M_NUM(M_NUM), .OST_DEPTH(OST_DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .M_WR_ADDR(w_m_awaddr), .M_WR_ADDR_LEN(w_m_awlen), .M_WR_ADDR_ID(w_m_awid),
        .M_WR_ADDR_VALID(m_awvalid), .M_WR_ADDR_READY(w_m_awready),
        .M_WR_DATA(w_m_wdata), .M_WR_DATA_LAST(m_wlast),
        .M_WR_DATA_VALID(m_wvalid), .M_WR_DATA_READY(w_m_wready),
        .M_WR_BACK_ID(w_m_bid), .M_WR_BACK_RESP(w_m_bresp),
        .M_WR_BACK_VALID(w_m_bvalid), .M_WR_BACK_READY(m_bready),
        .S_WR_ADDR(w_s_awaddr), .S_WR_ADDR_LEN(w_s_awlen), .S_WR_ADDR_ID(w_s_awid),
        .S_WR_ADDR_VALID(w_s_awvalid), .S_WR_ADDR_READY(s_awready),
        .S_WR_DATA(w_s_wdata), .S_WR_DATA_LAST(w_s_wlast),
        .S_WR_DATA_VALID(w_s_wvalid), .S_WR_DATA_READY(s_wready),
        .S_WR_BACK_ID(s_bid), .S_WR_BACK_RESP(s_bresp),
        .S_WR_BACK_VALID(s_bvalid), .S_WR_BACK_READY(w_s_bready),
        .bid_err(w_bid_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave response driver: answers outstanding addresses in acceptance order.
    initial begin
        s_bvalid = 1'b0;
        s_bid    = '0;
        s_bresp  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (s_resp_en && s_pend.size() != 0) begin
                s_bvalid = 1'b1;
                s_bid    = s_pend[0] ^ s_bid_xor;
                s_bresp  = s_resp_code;
            end else begin
                s_bvalid = 1'b0;
                s_bid    = '0;
                s_bresp  = '0;
            end
        end
    end

    // Monitor: pops expected entries whenever a handshake is presented.
    logic [43:0] ea;
    logic [32:0] ew;
    logic [7:0]  eb;
    always @(negedge clk) begin
        if (rstn) begin
            cyc++;
            if (w_s_awvalid && s_awready) begin
                if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
                else begin
                    ea = exp_aw.pop_front();
                    chk("aw_payload", {w_s_awaddr, w_s_awlen, w_s_awid}, ea);
                end
                if (gap_mode && have_last) chk("last_to_aw_gap", 64'(cyc - t_last), 2);
                s_pend.push_back(w_s_awid);
            end
            if (w_s_wvalid && s_wready) begin
                if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
                else begin
                    ew = exp_w.pop_front();
                    chk("w_beat", {w_s_wdata, w_s_wlast}, ew);
                end
                if (w_s_wlast) begin
                    t_last    = cyc;
                    have_last = 1'b1;
                end
            end
            if (s_bvalid && w_s_bready && s_pend.size() != 0) void'(s_pend.pop_front());
            for (int m = 0; m < M_NUM; m++) begin
                if (w_m_bvalid[m] && m_bready[m]) begin
                    if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
                    else begin
                        eb = exp_b.pop_front();
                        chk("b_master", 64'(m), 64'(eb[7:6]));
                        chk("b_id_resp", {w_m_bid[m*4 +: 4], w_m_bresp[m*2 +: 2]}, eb[5:0]);
                    end
                end
            end
        end
    end

    function automatic void push_burst(input int m, input logic [31:0] addr, input logic [7:0] len,
                                       input logic [3:0] id, input logic [31:0] dbase,
                                       input logic [3:0] bid, input logic [1:0] resp);
        exp_aw.push_back({addr, len, id});
        for (int k = 0; k <= int'(len); k++) exp_w.push_back({dbase + 32'(k), k == int'(len)});
        exp_b.push_back({2'(m), bid, resp});
    endfunction

    task automatic wait_rdy(input int kind, input int m, output bit ok);
        int t = 0;
        ok = 1'b0;
        while (t < 200) begin
            @(negedge clk);
            if ((kind == 0 && w_m_awready[m]) || (kind == 1 && w_m_wready[m])) begin
                ok = 1'b1;
                break;
            end
            t++;
        end
        if (!ok) begin
            if (kind == 0) chk("aw_ready_timeout", 0, 1);
            else           chk("w_ready_timeout", 0, 1);
        end
    endtask

    task automatic burst(input int m, input logic [31:0] addr, input logic [7:0] len,
                         input logic [3:0] id, input logic [31:0] dbase);
        bit ok;
        m_awaddr[m] = addr;
        m_awlen[m]  = len;
        m_awid[m]   = id;
        m_awvalid[m] = 1'b1;
        wait_rdy(0, m, ok);
        @(posedge clk);
        #1;
        m_awvalid[m] = 1'b0;
        if (!ok) return;
        for (int k = 0; k <= int'(len); k++) begin
            m_wdata[m]  = dbase + 32'(k);
            m_wlast[m]  = (k == int'(len));
            m_wvalid[m] = 1'b1;
            wait_rdy(1, m, ok);
            @(posedge clk);
            #1;
            m_wvalid[m] = 1'b0;
            m_wlast[m]  = 1'b0;
            if (!ok) return;
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_aw.size() + exp_w.size() + exp_b.size()) != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("drain_empty", 64'(exp_aw.size() + exp_w.size() + exp_b.size()), 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        m_awvalid = '0;
        m_wvalid  = '0;
        m_wlast   = '0;
        s_pend.delete();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {w_s_awvalid, w_s_wvalid, w_s_bready, w_m_awready,
                              w_m_wready, w_m_bvalid, w_bid_err}, 0);
    endtask

    bit blocked;
    bit ok5;
    initial begin
        rstn = 1'b0;
        for (int i = 0; i < M_NUM; i++) begin
            m_awaddr[i] = '0; m_awlen[i] = '0; m_awid[i] = '0; m_wdata[i] = '0;
        end
        m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '1;
        s_awready = 1'b1; s_wready = 1'b1;
        s_resp_en = 1'b1; s_resp_code = 2'b00; s_bid_xor = '0;

        // 1: single master, four-beat burst
        do_reset();
        push_burst(0, 32'h10, 8'd3, 4'd2, 32'h1000_0000, 4'd2, 2'b00);
        burst(0, 32'h10, 8'd3, 4'd2, 32'h1000_0000);
        drain();

        // 2: simultaneous requests alternate m0, m1, m0 with no interleaving
        do_reset();
        s_resp_code = 2'b01;
        push_burst(0, 32'h100, 8'd1, 4'd1, 32'hA000_0000, 4'd1, 2'b01);
        push_burst(1, 32'h200, 8'd1, 4'd7, 32'hB000_0000, 4'd7, 2'b01);
        push_burst(0, 32'h104, 8'd1, 4'd3, 32'hC000_0000, 4'd3, 2'b01);
        fork
            begin
                burst(0, 32'h100, 8'd1, 4'd1, 32'hA000_0000);
                burst(0, 32'h104, 8'd1, 4'd3, 32'hC000_0000);
            end
            burst(1, 32'h200, 8'd1, 4'd7, 32'hB000_0000);
        join
        drain();
        s_resp_code = 2'b00;

        // 3: back-to-back single beats from m1, one idle cycle between bursts
        do_reset();
        have_last = 1'b0;
        gap_mode  = 1'b1;
        for (int i = 0; i < 3; i++)
            push_burst(1, 32'h700 + 32'(i * 4), 8'd0, 4'(8 + i), 32'hD000_0000 + 32'(i * 16), 4'(8 + i), 2'b00);
        for (int i = 0; i < 3; i++)
            burst(1, 32'h700 + 32'(i * 4), 8'd0, 4'(8 + i), 32'hD000_0000 + 32'(i * 16));
        drain();
        gap_mode = 1'b0;

        // 4: full outstanding FIFO blocks the fifth grant until a response retires
        do_reset();
        s_resp_en = 1'b0;
        for (int i = 0; i < 5; i++)
            push_burst(0, 32'h500 + 32'(i * 16), 8'd0, 4'(1 + i), 32'hE000_0000 + 32'(i * 256), 4'(1 + i), 2'b00);
        for (int i = 0; i < 4; i++)
            burst(0, 32'h500 + 32'(i * 16), 8'd0, 4'(1 + i), 32'hE000_0000 + 32'(i * 256));
        fork
            burst(0, 32'h540, 8'd0, 4'd5, 32'hE000_0400);
            begin
                blocked = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    if (w_s_awvalid || (w_m_awready != '0)) blocked = 1'b0;
                end
                chk("full_blocks_grant", 64'(blocked), 1);
                s_resp_en = 1'b1;
            end
        join
        drain();

        // 5: reset on the second of four beats aborts the burst
        do_reset();
        s_resp_en = 1'b0;
        exp_aw.push_back({32'h300, 8'd3, 4'd4});
        exp_w.push_back({32'hF000_0000, 1'b0});
        m_awaddr[0] = 32'h300; m_awlen[0] = 8'd3; m_awid[0] = 4'd4; m_awvalid[0] = 1'b1;
        wait_rdy(0, 0, ok5);
        @(posedge clk); #1;
        m_awvalid[0] = 1'b0;
        m_wdata[0] = 32'hF000_0000; m_wlast[0] = 1'b0; m_wvalid[0] = 1'b1;
        wait_rdy(1, 0, ok5);
        @(posedge clk); #1;
        m_wdata[0] = 32'hF000_0001;
        rstn = 1'b0;
        s_pend.delete();
        m_awaddr[1] = 32'h400; m_awlen[1] = 8'd1; m_awid[1] = 4'd9; m_awvalid[1] = 1'b1;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_abort_outputs", {w_s_awvalid, w_s_wvalid, w_s_bready, w_m_awready,
                                  w_m_wready, w_m_bvalid}, 0);
        chk("rst_abort_beats", 64'(exp_aw.size() + exp_w.size()), 0);
        m_wvalid[0] = 1'b0;
        s_resp_en = 1'b1;
        push_burst(1, 32'h400, 8'd1, 4'd9, 32'h9000_0000, 4'd9, 2'b00);
        burst(1, 32'h400, 8'd1, 4'd9, 32'h9000_0000);
        drain();

        // 6: response ID mismatch (stored 3, returned 5) then a matching response
        do_reset();
        s_bid_xor = 4'h6;
        push_burst(0, 32'h600, 8'd0, 4'd3, 32'h6000_0000, 4'd5, 2'b00);
        burst(0, 32'h600, 8'd0, 4'd3, 32'h6000_0000);
        drain();
        s_bid_xor = 4'h0;
        chk("bid_err_after_mismatch", 64'(w_bid_err), 64'(BID_EXP));
        push_burst(0, 32'h610, 8'd0, 4'd3, 32'h6100_0000, 4'd3, 2'b00);
        burst(0, 32'h610, 8'd0, 4'd3, 32'h6100_0000);
        drain();
        chk("bid_err_sticky", 64'(w_bid_err), 64'(BID_EXP));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
